// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared geometry defaults, FSM state type and signed coordinate type for the Pong engine
package pong_pkg;

    localparam int DEF_SCREEN_W     = 640;
    localparam int DEF_SCREEN_H     = 480;
    localparam int DEF_BALL_SIZE    = 8;
    localparam int DEF_PADDLE_W     = 8;
    localparam int DEF_PADDLE_H     = 64;
    localparam int DEF_PADDLE_ONE_X = 16;
    localparam int DEF_PADDLE_TWO_X = 616;
    localparam int DEF_BALL_SPEED   = 2;
    localparam int DEF_PADDLE_SPEED = 4;
    localparam int DEF_SERVE_FRAMES = 60;

    // Wide enough to hold a step past either screen edge without wrapping.
    typedef logic signed [10:0] coord_t;

    typedef enum logic [1:0] {
        SERVE  = 2'd0,
        PLAY   = 2'd1,
        SCORED = 2'd2
    } state_t;

endpackage

// File: rtl/pong_paddle_ctrl.sv
// rtl/pong_paddle_ctrl.sv - one paddle: button synchronizer, per-frame move and clamp
// Ports: clk, reset (sync, active-high), tick (frame strobe), btn_up/btn_down (async),
//        paddle_y (10-bit top-left y, clamped to [0, Y_MAX])
module pong_paddle_ctrl
    import pong_pkg::*;
#(
    parameter int STEP    = DEF_PADDLE_SPEED,
    parameter int Y_MAX   = DEF_SCREEN_H - DEF_PADDLE_H,
    parameter int Y_RESET = (DEF_SCREEN_H - DEF_PADDLE_H) / 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [9:0] paddle_y
);

    localparam coord_t STEP_C  = coord_t'(STEP);
    localparam coord_t Y_MAX_C = coord_t'(Y_MAX);
    localparam coord_t ZERO_C  = '0;

    logic [1:0] up_sync_q, up_sync_d;
    logic [1:0] down_sync_q, down_sync_d;
    logic [9:0] y_q, y_d;
    coord_t     y_cur;
    coord_t     y_move;
    logic       go_up, go_down;

    always_comb begin
        up_sync_d   = {up_sync_q[0], btn_up};
        down_sync_d = {down_sync_q[0], btn_down};
    end

    // Both buttons held cancel out.
    assign go_up   = up_sync_q[1] & ~down_sync_q[1];
    assign go_down = down_sync_q[1] & ~up_sync_q[1];
    assign y_cur   = coord_t'({1'b0, y_q});

    always_comb begin
        y_move = y_cur;
        if (go_up) begin
            y_move = y_cur - STEP_C;
        end else if (go_down) begin
            y_move = y_cur + STEP_C;
        end
    end

    always_comb begin
        y_d = y_q;
        if (tick) begin
            if (y_move < ZERO_C) begin
                y_d = '0;
            end else if (y_move > Y_MAX_C) begin
                y_d = Y_MAX_C[9:0];
            end else begin
                y_d = y_move[9:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            up_sync_q   <= '0;
            down_sync_q <= '0;
            y_q         <= 10'(Y_RESET);
        end else begin
            up_sync_q   <= up_sync_d;
            down_sync_q <= down_sync_d;
            y_q         <= y_d;
        end
    end

    assign paddle_y = y_q;

endmodule

// File: rtl/pong_game_engine.sv
// rtl/pong_game_engine.sv - per-frame Pong state: ball physics, collisions, paddles, serve and scoring
// Ports: clk50M, reset (sync, active-high), VS (active-low vsync, same domain),
//        p1_up/p1_down/p2_up/p2_down (async buttons),
//        ball_x/ball_y, paddle_one_x/y, paddle_two_x/y (10-bit top-left), score_one/score_two (BCD 0-9)
// Option macro PONG_CPU_PLAYER_EN: paddle two follows the ball and ignores p2_up/p2_down.
module pong_game_engine
    import pong_pkg::*;
#(
    parameter int SCREEN_W     = DEF_SCREEN_W,
    parameter int SCREEN_H     = DEF_SCREEN_H,
    parameter int BALL_SIZE    = DEF_BALL_SIZE,
    parameter int PADDLE_W     = DEF_PADDLE_W,
    parameter int PADDLE_H     = DEF_PADDLE_H,
    parameter int PADDLE_ONE_X = DEF_PADDLE_ONE_X,
    parameter int PADDLE_TWO_X = DEF_PADDLE_TWO_X,
    parameter int BALL_SPEED   = DEF_BALL_SPEED,
    parameter int PADDLE_SPEED = DEF_PADDLE_SPEED,
    parameter int SERVE_FRAMES = DEF_SERVE_FRAMES
) (
    input  logic       clk50M,
    input  logic       reset,
    input  logic       VS,
    input  logic       p1_up,
    input  logic       p1_down,
    input  logic       p2_up,
    input  logic       p2_down,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [9:0] paddle_one_x,
    output logic [9:0] paddle_one_y,
    output logic [9:0] paddle_two_x,
    output logic [9:0] paddle_two_y,
    output logic [3:0] score_one,
    output logic [3:0] score_two
);

    localparam int               CNT_W      = $clog2(SERVE_FRAMES);
    localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
    localparam logic [9:0]       BALL_X0    = 10'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [9:0]       BALL_Y0    = 10'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic [9:0]       RIGHT_STOP = 10'(PADDLE_TWO_X - BALL_SIZE);
    localparam coord_t SPEED_C      = coord_t'(BALL_SPEED);
    localparam coord_t SIZE_C       = coord_t'(BALL_SIZE);
    localparam coord_t PAD_H_C      = coord_t'(PADDLE_H);
    localparam coord_t LEFT_FACE_C  = coord_t'(PADDLE_ONE_X + PADDLE_W);
    localparam coord_t RIGHT_FACE_C = coord_t'(PADDLE_TWO_X);
    localparam coord_t X_MAX_C      = coord_t'(SCREEN_W - BALL_SIZE);
    localparam coord_t Y_MAX_C      = coord_t'(SCREEN_H - BALL_SIZE);
    localparam coord_t ZERO_C       = '0;

    state_t           state_q, state_d;
    logic             vs_q, vs_d;
    logic             tick;
    logic [CNT_W-1:0] serve_cnt_q, serve_cnt_d;
    logic             serve_pos_q, serve_pos_d;   // 1: serve toward +x
    logic             dx_pos_q, dx_pos_d;         // 1: dx = +1
    logic             dy_pos_q, dy_pos_d;         // 1: dy = +1
    logic             scorer_one_q, scorer_one_d; // 1: player one won the rally
    logic [9:0]       ball_x_q, ball_x_d;
    logic [9:0]       ball_y_q, ball_y_d;
    logic [3:0]       score_one_q, score_one_d;
    logic [3:0]       score_two_q, score_two_d;
    logic [9:0]       paddle_one_y_w, paddle_two_y_w;

    coord_t bx, by, nx, ny, p1y, p2y;
    logic   hit_left, hit_right, miss_left, miss_right;

    // Frame strobe on the falling edge of VS.
    assign vs_d = VS;
    assign tick = vs_q & ~VS;

    // ---------------- paddles ----------------
    pong_paddle_ctrl #(
        .STEP   (PADDLE_SPEED),
        .Y_MAX  (SCREEN_H - PADDLE_H),
        .Y_RESET((SCREEN_H - PADDLE_H) / 2)
    ) u_paddle_one (
        .clk     (clk50M),
        .reset   (reset),
        .tick    (tick),
        .btn_up  (p1_up),
        .btn_down(p1_down),
        .paddle_y(paddle_one_y_w)
    );

`ifdef PONG_CPU_PLAYER_EN
    localparam coord_t HOLD_C = coord_t'(4);
    coord_t ball_mid, pad_mid;
    logic   cpu_up, cpu_down;

    // Steer paddle two's centre toward the ball's centre, with a small dead band.
    always_comb begin
        ball_mid = by + coord_t'(BALL_SIZE / 2);
        pad_mid  = p2y + coord_t'(PADDLE_H / 2);
        cpu_up   = ball_mid < (pad_mid - HOLD_C);
        cpu_down = ball_mid > (pad_mid + HOLD_C);
    end

    pong_paddle_ctrl #(
        .STEP   (PADDLE_SPEED / 2),
        .Y_MAX  (SCREEN_H - PADDLE_H),
        .Y_RESET((SCREEN_H - PADDLE_H) / 2)
    ) u_paddle_two (
        .clk     (clk50M),
        .reset   (reset),
        .tick    (tick),
        .btn_up  (cpu_up),
        .btn_down(cpu_down),
        .paddle_y(paddle_two_y_w)
    );
`else
    pong_paddle_ctrl #(
        .STEP   (PADDLE_SPEED),
        .Y_MAX  (SCREEN_H - PADDLE_H),
        .Y_RESET((SCREEN_H - PADDLE_H) / 2)
    ) u_paddle_two (
        .clk     (clk50M),
        .reset   (reset),
        .tick    (tick),
        .btn_up  (p2_up),
        .btn_down(p2_down),
        .paddle_y(paddle_two_y_w)
    );
`endif

    // ---------------- collision detection ----------------
    assign bx  = coord_t'({1'b0, ball_x_q});
    assign by  = coord_t'({1'b0, ball_y_q});
    assign p1y = coord_t'({1'b0, paddle_one_y_w});
    assign p2y = coord_t'({1'b0, paddle_two_y_w});
    assign nx  = dx_pos_q ? (bx + SPEED_C) : (bx - SPEED_C);
    assign ny  = dy_pos_q ? (by + SPEED_C) : (by - SPEED_C);

    // A hit needs the ball to cross the paddle face this frame, not already be past it.
    assign hit_left  = ~dx_pos_q && (nx <= LEFT_FACE_C) && (bx >= LEFT_FACE_C)
                    && ((by + SIZE_C) > p1y) && (by < (p1y + PAD_H_C));
    assign hit_right = dx_pos_q && ((nx + SIZE_C) >= RIGHT_FACE_C) && ((bx + SIZE_C) <= RIGHT_FACE_C)
                    && ((by + SIZE_C) > p2y) && (by < (p2y + PAD_H_C));
    // A paddle hit wins over a miss on the same frame.
    assign miss_left  = ~hit_left && ~hit_right && (nx <= ZERO_C);
    assign miss_right = ~hit_left && ~hit_right && (nx >= X_MAX_C);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk50M) begin
        if (reset) begin
            state_q <= SERVE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (tick) begin
            case (state_q)
                SERVE:   if (serve_cnt_q == SERVE_LAST) state_d = PLAY;
                PLAY:    if (miss_left || miss_right) state_d = SCORED;
                SCORED:  state_d = SERVE;
                default: state_d = SERVE;
            endcase
        end
    end

    // ---------------- FSM: ball, serve and score updates ----------------
    always_comb begin
        serve_cnt_d  = serve_cnt_q;
        serve_pos_d  = serve_pos_q;
        dx_pos_d     = dx_pos_q;
        dy_pos_d     = dy_pos_q;
        scorer_one_d = scorer_one_q;
        ball_x_d     = ball_x_q;
        ball_y_d     = ball_y_q;
        score_one_d  = score_one_q;
        score_two_d  = score_two_q;
        if (tick) begin
            case (state_q)
                SERVE: begin
                    ball_x_d = BALL_X0;
                    ball_y_d = BALL_Y0;
                    if (serve_cnt_q == SERVE_LAST) begin
                        serve_cnt_d = '0;
                        dx_pos_d    = serve_pos_q;
                        dy_pos_d    = 1'b1;
                    end else begin
                        serve_cnt_d = serve_cnt_q + CNT_W'(1);
                    end
                end
                PLAY: begin
                    // Vertical and horizontal axes resolve independently.
                    if (ny <= ZERO_C) begin
                        ball_y_d = '0;
                        dy_pos_d = 1'b1;
                    end else if (ny >= Y_MAX_C) begin
                        ball_y_d = Y_MAX_C[9:0];
                        dy_pos_d = 1'b0;
                    end else begin
                        ball_y_d = ny[9:0];
                    end
                    if (hit_left) begin
                        ball_x_d = LEFT_FACE_C[9:0];
                        dx_pos_d = 1'b1;
                    end else if (hit_right) begin
                        ball_x_d = RIGHT_STOP;
                        dx_pos_d = 1'b0;
                    end else if (miss_left) begin
                        ball_x_d     = '0;
                        scorer_one_d = 1'b0;
                    end else if (miss_right) begin
                        ball_x_d     = X_MAX_C[9:0];
                        scorer_one_d = 1'b1;
                    end else begin
                        ball_x_d = nx[9:0];
                    end
                end
                SCORED: begin
                    if (scorer_one_q) begin
                        score_one_d = (score_one_q == 4'd9) ? 4'd0 : score_one_q + 4'd1;
                    end else begin
                        score_two_d = (score_two_q == 4'd9) ? 4'd0 : score_two_q + 4'd1;
                    end
                    ball_x_d    = BALL_X0;
                    ball_y_d    = BALL_Y0;
                    // Next serve heads toward whoever conceded.
                    serve_pos_d = scorer_one_q;
                end
                default: begin
                    ball_x_d = BALL_X0;
                    ball_y_d = BALL_Y0;
                end
            endcase
        end
    end

    always_ff @(posedge clk50M) begin
        if (reset) begin
            vs_q         <= 1'b0;
            serve_cnt_q  <= '0;
            serve_pos_q  <= 1'b1;
            dx_pos_q     <= 1'b1;
            dy_pos_q     <= 1'b1;
            scorer_one_q <= 1'b0;
            ball_x_q     <= BALL_X0;
            ball_y_q     <= BALL_Y0;
            score_one_q  <= '0;
            score_two_q  <= '0;
        end else begin
            vs_q         <= vs_d;
            serve_cnt_q  <= serve_cnt_d;
            serve_pos_q  <= serve_pos_d;
            dx_pos_q     <= dx_pos_d;
            dy_pos_q     <= dy_pos_d;
            scorer_one_q <= scorer_one_d;
            ball_x_q     <= ball_x_d;
            ball_y_q     <= ball_y_d;
            score_one_q  <= score_one_d;
            score_two_q  <= score_two_d;
        end
    end

    assign ball_x       = ball_x_q;
    assign ball_y       = ball_y_q;
    assign paddle_one_x = 10'(PADDLE_ONE_X);
    assign paddle_two_x = 10'(PADDLE_TWO_X);
    assign paddle_one_y = paddle_one_y_w;
    assign paddle_two_y = paddle_two_y_w;
    assign score_one    = score_one_q;
    assign score_two    = score_two_q;

endmodule

// File: tb/tb_pong_game_engine.sv
// tb/tb_pong_game_engine.sv - directed-vector bench for pong_game_engine
module tb_pong_game_engine;

    logic       clk50M = 1'b0;
    logic       reset = 1'b0;
    logic       VS = 1'b1;
    logic       p1_up = 1'b0, p1_down = 1'b0, p2_up = 1'b0, p2_down = 1'b0;
    logic [9:0] ball_x, ball_y, paddle_one_x, paddle_one_y, paddle_two_x, paddle_two_y;
    logic [3:0] score_one, score_two;

    int n_cmp = 0;
    int n_bad = 0;
    int gtick = 0;

    always #10 clk50M = ~clk50M;

    pong_game_engine dut (
        .clk50M      (clk50M),
        .reset       (reset),
        .VS          (VS),
        .p1_up       (p1_up),
        .p1_down     (p1_down),
        .p2_up       (p2_up),
        .p2_down     (p2_down),
        .ball_x      (ball_x),
        .ball_y      (ball_y),
        .paddle_one_x(paddle_one_x),
        .paddle_one_y(paddle_one_y),
        .paddle_two_x(paddle_two_x),
        .paddle_two_y(paddle_two_y),
        .score_one   (score_one),
        .score_two   (score_two)
    );

    typedef struct {
        bit rst;
        int to_tick;
        bit p1u, p1d, p2u, p2d;
        int bx, by, p1y, p2y, s1, s2;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit rst, input int to_tick, input bit p1u, input bit p1d,
                       input bit p2u, input bit p2d, input int bx, input int by,
                       input int p1y, input int p2y, input int s1, input int s2);
        vecs.push_back('{rst, to_tick, p1u, p1d, p2u, p2d, bx, by, p1y, p2y, s1, s2});
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int bx, input int by, input int p1y,
                           input int p2y, input int s1, input int s2);
        chk({tag, ".ball_x"}, int'(ball_x), bx);
        chk({tag, ".ball_y"}, int'(ball_y), by);
        chk({tag, ".paddle_one_y"}, int'(paddle_one_y), p1y);
        chk({tag, ".paddle_two_y"}, int'(paddle_two_y), p2y);
        chk({tag, ".score_one"}, int'(score_one), s1);
        chk({tag, ".score_two"}, int'(score_two), s2);
    endtask

    task automatic do_reset();
        @(negedge clk50M) reset = 1'b1;
        @(negedge clk50M) reset = 1'b0;
        gtick = 0;
    endtask

    // One frame: VS held low three cycles, so only its falling edge may count.
    task automatic do_tick();
        @(negedge clk50M) VS = 1'b0;
        repeat (3) @(negedge clk50M);
        VS = 1'b1;
        repeat (3) @(negedge clk50M);
        gtick++;
    endtask

    initial begin
        // Scoring run: idle paddles, player one wins every rally, 9 wraps to 0.
        add(1,    3, 0,0,0,0, 316,236, 208,208, 0,0);
        add(0,    8, 1,1,1,1, 316,236, 208,208, 0,0);
        add(0,   10, 0,1,0,0, 316,236, 216,208, 0,0);
        add(0,   12, 0,0,1,0, 316,236, 216,200, 0,0);
        add(0,  218, 0,0,0,0, 632,392, 216,200, 0,0);
        add(0,  219, 0,0,0,0, 316,236, 216,200, 1,0);
        add(0, 1971, 0,0,0,0, 316,236, 216,200, 9,0);
        add(0, 2189, 0,0,0,0, 632,392, 216,200, 9,0);
        add(0, 2190, 0,0,0,0, 316,236, 216,200, 0,0);
        // Rally: right paddle returns, left paddle (moved to 160) returns at x=26 -> 24.
        add(1,   12, 1,0,0,1, 316,236, 160,256, 0,0);
        add(0,   52, 0,0,0,1, 316,236, 160,416, 0,0);
        add(0,  206, 0,0,0,1, 608,416, 160,416, 0,0);
        add(0,  207, 0,0,0,1, 606,414, 160,416, 0,0);
        add(0,  497, 0,0,0,1,  26,166, 160,416, 0,0);
        add(0,  498, 0,0,0,1,  24,168, 160,416, 0,0);
        add(0,  499, 0,0,0,1,  26,170, 160,416, 0,0);
        // Clamp run: paddle one pinned at 0, ball slips past, player two scores, serve goes left.
        add(1,    1, 1,0,0,1, 316,236, 204,212, 0,0);
        add(0,    2, 1,0,0,1, 316,236, 200,216, 0,0);
        add(0,   51, 1,0,0,1, 316,236,   4,412, 0,0);
        add(0,   52, 1,0,0,1, 316,236,   0,416, 0,0);
        add(0,   60, 1,0,0,1, 316,236,   0,416, 0,0);
        add(0,   61, 1,0,0,1, 318,238,   0,416, 0,0);
        add(0,  178, 1,0,0,1, 552,472,   0,416, 0,0);
        add(0,  179, 1,0,0,1, 554,470,   0,416, 0,0);
        add(0,  206, 1,0,0,1, 608,416,   0,416, 0,0);
        add(0,  413, 1,0,0,1, 194,  2,   0,416, 0,0);
        add(0,  414, 1,0,0,1, 192,  0,   0,416, 0,0);
        add(0,  415, 1,0,0,1, 190,  2,   0,416, 0,0);
        add(0,  510, 1,0,0,1,   0,192,   0,416, 0,0);
        add(0,  511, 1,0,0,1, 316,236,   0,416, 0,1);
        add(0,  571, 1,0,0,1, 316,236,   0,416, 0,1);
        add(0,  572, 1,0,0,1, 314,238,   0,416, 0,1);
        add(0,  575, 1,0,0,1, 308,244,   0,416, 0,1);

        // Reset state, including the fixed paddle x positions.
        do_reset();
        @(negedge clk50M);
        chk_all("reset", 316, 236, 208, 208, 0, 0);
        chk("reset.paddle_one_x", int'(paddle_one_x), 16);
        chk("reset.paddle_two_x", int'(paddle_two_x), 616);

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            p1_up   = vecs[i].p1u;
            p1_down = vecs[i].p1d;
            p2_up   = vecs[i].p2u;
            p2_down = vecs[i].p2d;
            repeat (3) @(negedge clk50M);
            while (gtick < vecs[i].to_tick) do_tick();
            chk_all($sformatf("v%0d_t%0d", i, vecs[i].to_tick), vecs[i].bx, vecs[i].by,
                    vecs[i].p1y, vecs[i].p2y, vecs[i].s1, vecs[i].s2);
        end

        // Reset mid-PLAY and mid-frame: reset values on the very next edge.
        @(negedge clk50M) reset = 1'b1;
        @(posedge clk50M) #1;
        chk_all("midreset", 316, 236, 208, 208, 0, 0);
        @(negedge clk50M) reset = 1'b0;
        p1_up = 1'b0;
        p2_down = 1'b0;
        gtick = 0;
        repeat (3) @(negedge clk50M);
        do_tick();
        chk_all("midreset_t1", 316, 236, 208, 208, 0, 0);

        // Output timing: unchanged before the tick edge, updated right after it.
        p1_down = 1'b1;
        repeat (3) @(negedge clk50M);
        VS = 1'b0;
        chk("latency.before", int'(paddle_one_y), 208);
        @(posedge clk50M) #1;
        chk("latency.after", int'(paddle_one_y), 212);
        @(negedge clk50M) VS = 1'b1;
        repeat (3) @(negedge clk50M);
        chk("latency.hold", int'(paddle_one_y), 212);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
